// File: rtl/hyperbus_read_seq.sv
// HyperBus read-burst sequencer: waits the initial latency, gates the RWDS read
// clock, passes CDC FIFO beats downstream, and recovers from timeout or abort.
module hyperbus_read_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned FLUSH_CYCLES   = 8
) (
    input  logic        clk0,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_len_i,
    input  logic [7:0]  cfg_latency_i,
    input  logic        abort_i,
    output logic        read_clk_en_o,
    input  logic        fifo_valid_i,
    input  logic [15:0] fifo_data_i,
    output logic        fifo_ready_o,
    output logic        rx_valid_o,
    output logic [15:0] rx_data_o,
    output logic        rx_last_o,
    input  logic        rx_ready_i,
    output logic        done_o,
    output logic        done_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATENCY = 2'd1,
        ST_READ    = 2'd2,
        ST_FLUSH   = 2'd3
    } state_e;

    // One shared cycle counter serves latency, timeout and flush timing.
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam int unsigned FW  = $clog2(FLUSH_CYCLES + 32'd1);
    localparam int unsigned CW0 = (TW > FW) ? TW : FW;
    localparam int unsigned CW  = (CW0 > 32'd8) ? CW0 : 32'd8;
    localparam logic [CW-1:0] TMO_LIMIT  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FLUSH_LAST = (FLUSH_CYCLES > 32'd0) ? CW'(FLUSH_CYCLES - 32'd1)
                                                                  : {CW{1'b0}};

    function automatic logic [7:0] eff_latency(input logic [7:0] lat);
        return (lat == 8'd0) ? 8'd1 : lat;
    endfunction

    state_e        state_r, state_s;
    logic [15:0]   len_r, len_s;
    logic [7:0]    lat_r, lat_s;
    logic [15:0]   beat_cnt_r, beat_cnt_s;
    logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic          read_clk_en_r, done_r, done_err_r;
    logic          done_s, done_err_s;
    logic          beat_s, accept_s;

    assign cnt_inc_s     = cnt_r + CW'(1);
    assign beat_s        = rx_valid_o && rx_ready_i;
    assign accept_s      = cmd_valid_i && cmd_ready_o;
    assign read_clk_en_o = read_clk_en_r;
    assign done_o        = done_r;
    assign done_err_o    = done_err_r;

    // Handshake and pass-through decode; IDLE readiness stays low while in reset
    always_comb begin
        cmd_ready_o  = 1'b0;
        fifo_ready_o = 1'b0;
        rx_valid_o   = 1'b0;
        rx_data_o    = 16'h0000;
        rx_last_o    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready_o  = rst_ni;
                fifo_ready_o = rst_ni;
            end
            ST_READ: begin
                rx_valid_o   = fifo_valid_i;
                rx_data_o    = fifo_data_i;
                fifo_ready_o = rx_ready_i;
                rx_last_o    = fifo_valid_i && (beat_cnt_r == len_r);
            end
            ST_FLUSH: begin
                fifo_ready_o = 1'b1;
            end
            default: begin
                cmd_ready_o = 1'b0;
            end
        endcase
    end

    // Next-state, counter and completion logic
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        lat_s      = lat_r;
        beat_cnt_s = beat_cnt_r;
        cnt_s      = cnt_r;
        done_s     = 1'b0;
        done_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s    = ST_LATENCY;
                    len_s      = cmd_len_i;
                    lat_s      = cfg_latency_i;
                    beat_cnt_s = 16'h0000;
                    cnt_s      = {CW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LATENCY: begin
                if (abort_i) begin
                    state_s = ST_FLUSH;
                    cnt_s   = {CW{1'b0}};
                end else if (cnt_inc_s >= CW'(eff_latency(lat_r))) begin
                    state_s = ST_READ;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_READ: begin
                // Completing the final beat wins over a coincident abort
                if (beat_s && rx_last_o) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if (abort_i) begin
                    state_s = ST_FLUSH;
                    cnt_s   = {CW{1'b0}};
                end else if (beat_s) begin
                    beat_cnt_s = (beat_cnt_r == 16'hFFFF) ? beat_cnt_r : beat_cnt_r + 16'd1;
                    cnt_s      = {CW{1'b0}};
                end else if (cnt_inc_s >= TMO_LIMIT) begin
                    state_s = ST_FLUSH;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_FLUSH: begin
                // Minimum dwell covers CDC latency, then drain until the FIFO is empty
                if ((cnt_r >= FLUSH_LAST) && !fifo_valid_i) begin
                    state_s    = ST_IDLE;
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                end else if (cnt_r < FLUSH_LAST) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk0 or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            len_r         <= 16'h0000;
            lat_r         <= 8'h00;
            beat_cnt_r    <= 16'h0000;
            cnt_r         <= {CW{1'b0}};
            read_clk_en_r <= 1'b0;
            done_r        <= 1'b0;
            done_err_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            len_r         <= len_s;
            lat_r         <= lat_s;
            beat_cnt_r    <= beat_cnt_s;
            cnt_r         <= cnt_s;
            read_clk_en_r <= (state_s == ST_READ);
            done_r        <= done_s;
            done_err_r    <= done_err_s;
        end
    end

endmodule

// File: doc/hyperbus_read_seq.md
HYPERBUS_READ_SEQ -- requirements
Module: hyperbus_read_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the max clk0 cycles with no accepted beat in READ before an error abort.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 8, meaning the cycles spent discarding FIFO output after an error or abort (covers CDC sync latency).
REQ-003 SHALL have port clk0  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  the reset, asynchronous and active-low.
REQ-005 SHALL have ports cmd_valid_i  input  1, cmd_ready_o  output  1, and cmd_len_i  input  16: the command handshake, where cmd_len_i is the beat count minus 1.
REQ-006 SHALL have port cfg_latency_i  input  8  the clk0 cycles to wait after command acceptance before enabling the read clock.
REQ-007 SHALL have port abort_i  input  1  the request to terminate the current burst.
REQ-008 SHALL have port read_clk_en_o  output  1  the read-clock gate enable to the RWDS read path.
REQ-009 SHALL have ports fifo_valid_i  input  1, fifo_data_i  input  16, and fifo_ready_o  output  1, forming the clk0 side of the read CDC FIFO.
REQ-010 SHALL have ports rx_valid_o  output  1, rx_data_o  output  16, rx_last_o  output  1, and rx_ready_i  input  1, forming the downstream beat stream.
REQ-011 SHALL have ports done_o  output  1 (one-cycle completion pulse) and done_err_o  output  1 (qualifies done_o: timeout or abort).

Function
REQ-012 SHALL implement the states IDLE, LATENCY, READ and FLUSH.
REQ-013 In IDLE, the block SHALL assert cmd_ready_o=1, fifo_ready_o=1 and rx_valid_o=0, and SHALL discard any stray FIFO words.
REQ-014 When cmd_valid_i&&cmd_ready_o, the block SHALL latch cmd_len_i and cfg_latency_i, clear the beat counter, and enter LATENCY.
REQ-015 LATENCY SHALL last exactly max(latched latency,1) cycles, keep read_clk_en_o=0, fifo_ready_o=0, rx_valid_o=0, and then enter READ.
REQ-016 read_clk_en_o SHALL be registered and equal 1 exactly in the cycles the FSM is in READ.
REQ-017 In READ, the block SHALL drive rx_valid_o=fifo_valid_i, rx_data_o=fifo_data_i and fifo_ready_o=rx_ready_i combinationally, giving zero-latency pass-through.
REQ-018 A beat SHALL be counted when rx_valid_o&&rx_ready_i in READ.
REQ-019 The 16-bit beat counter SHALL increment per beat and never wrap within a burst.
REQ-020 rx_last_o SHALL equal rx_valid_o && (beat count == latched len).
REQ-021 On the beat with rx_last_o=1, the block SHALL enter IDLE next cycle and pulse done_o=1 with done_err_o=0 in that cycle.
REQ-022 The timeout counter SHALL clear on entering READ and on every beat, and increment on every other READ cycle.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL enter FLUSH.
REQ-024 Backpressure stalls (fifo_valid_i=1, rx_ready_i=0) SHALL also count toward the timeout.
REQ-025 abort_i=1 in LATENCY or READ SHALL enter FLUSH next cycle.
REQ-026 abort_i SHALL be ignored in IDLE and FLUSH.
REQ-027 If abort_i coincides with the last beat, the beat SHALL complete, and completion SHALL take precedence with no error.
REQ-028 FLUSH SHALL keep read_clk_en_o=0, fifo_ready_o=1 and rx_valid_o=0, and last FLUSH_CYCLES cycles.
REQ-029 FLUSH SHALL then extend while fifo_valid_i=1, then enter IDLE, pulsing done_o=1 and done_err_o=1 in that cycle.
REQ-030 cmd_ready_o SHALL be 0 in every state except IDLE; a command offered in the done_o cycle SHALL be accepted.
REQ-031 A new command SHALL never be accepted while read_clk_en_o=1.

Reset
REQ-032 Asserting rst_ni=0 SHALL immediately force IDLE, clear the counters, and clear the latched len.
REQ-033 During reset, read_clk_en_o, done_o and done_err_o SHALL be 0, and cmd_ready_o, fifo_ready_o, rx_valid_o and rx_last_o SHALL be 0.
REQ-034 The first cycle after rst_ni deasserts SHALL present IDLE outputs (cmd_ready_o=1, fifo_ready_o=1, rx_valid_o=0).
REQ-035 Reset mid-burst SHALL drop read_clk_en_o without a done_o pulse.

Verification
REQ-036 The bench SHALL cover: len=3, latency=4, FIFO always valid, rx_ready_i=1 -> read_clk_en_o high 4 cycles starting 4 cycles after accept, 4 beats, rx_last_o on 4th, done_o=1/done_err_o=0 next cycle.
REQ-037 The bench SHALL cover: len=7 with random rx_ready_i backpressure, gaps shorter than TIMEOUT_CYCLES -> exactly 8 beats in order, data unmodified, no done_err_o.
REQ-038 The bench SHALL cover: len=15, FIFO stops after 5 beats -> after TIMEOUT_CYCLES idle cycles, FLUSH, read_clk_en_o=0, done_o=done_err_o=1 after FLUSH_CYCLES, rx_last_o never asserted.
REQ-039 The bench SHALL cover: abort_i during LATENCY and on the final beat -> first gives error completion with zero beats; second gives normal completion, done_err_o=0.
REQ-040 The bench SHALL cover: stray fifo_valid_i in IDLE plus cmd_valid_i held in the done_o cycle -> stray words consumed with rx_valid_o=0, back-to-back command accepted.
REQ-041 The bench SHALL cover: rst_ni pulsed low mid-READ at beat 2 of 8 -> read_clk_en_o=0 asynchronously, no done_o, clean IDLE and a fresh burst completing correctly.
